// File: rtl/seqtx_97.sv
// seqtx_97: FIFO-buffered parallel-to-serial byte transmitter, MSB first, gap-free frames.
// Define SEQTX_PARITY_EN to append an even-parity bit to each frame (9-bit frames).
module seqtx_97 #(
  parameter int DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] InData,
  input  logic       InValid,
  output logic       InReady,
  output logic       Out,
  output logic       OutValid,
  output logic       ByteDone,
  output logic       Busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef SEQTX_PARITY_EN
  localparam int NW = 4;
  localparam logic [NW-1:0] CNT_INIT = 4'd8;
`else
  localparam int NW = 3;
  localparam logic [NW-1:0] CNT_INIT = 3'd7;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

`ifdef SEQTX_PARITY_EN
  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  state_t        state_r;
  logic [7:0]    shreg_r;
  logic [NW-1:0] cnt_r;
  logic          out_r;
  logic          out_valid_r;
  logic          byte_done_r;
`ifdef SEQTX_PARITY_EN
  logic          par_r;
`endif

  logic          push_s;
  logic          load_s;
  logic [7:0]    head_s;

  assign InReady  = (count_r != CW'(DEPTH));
  assign Busy     = (count_r != {CW{1'b0}}) || (state_r == ST_SHIFT);
  assign Out      = out_r;
  assign OutValid = out_valid_r;
  assign ByteDone = byte_done_r;

  // Handshake decode; the shifter pops only when idle or leaving the final bit.
  always_comb begin
    push_s = InValid && InReady;
    head_s = mem_r[rd_ptr_r];
    load_s = 1'b0;
    if (count_r != {CW{1'b0}}) begin
      if (state_r == ST_IDLE) begin
        load_s = 1'b1;
      end else if (cnt_r == {NW{1'b0}}) begin
        load_s = 1'b1;
      end else begin
        load_s = 1'b0;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // FIFO storage; pointers are reset instead of the contents.
  always_ff @(posedge Clk) begin
    if (push_s && !Reset) begin
      mem_r[wr_ptr_r] <= InData;
    end
  end

  // FIFO bookkeeping plus shifter state machine with registered serial outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      state_r     <= ST_IDLE;
      shreg_r     <= 8'h00;
      cnt_r       <= {NW{1'b0}};
      out_r       <= 1'b0;
      out_valid_r <= 1'b0;
      byte_done_r <= 1'b0;
`ifdef SEQTX_PARITY_EN
      par_r       <= 1'b0;
`endif
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, load_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase

      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            state_r     <= ST_SHIFT;
            shreg_r     <= head_s;
            cnt_r       <= CNT_INIT;
            out_r       <= head_s[7];
            out_valid_r <= 1'b1;
            byte_done_r <= 1'b0;
`ifdef SEQTX_PARITY_EN
            par_r       <= even_par(head_s);
`endif
          end else begin
            out_r       <= 1'b0;
            out_valid_r <= 1'b0;
            byte_done_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cnt_r != {NW{1'b0}}) begin
            shreg_r     <= {shreg_r[6:0], 1'b0};
            cnt_r       <= cnt_r - NW'(1);
`ifdef SEQTX_PARITY_EN
            // After bit 0 the parity bit takes the output slot.
            out_r       <= (cnt_r == NW'(1)) ? par_r : shreg_r[6];
`else
            out_r       <= shreg_r[6];
`endif
            out_valid_r <= 1'b1;
            byte_done_r <= (cnt_r == NW'(1));
          end else if (load_s) begin
            shreg_r     <= head_s;
            cnt_r       <= CNT_INIT;
            out_r       <= head_s[7];
            out_valid_r <= 1'b1;
            byte_done_r <= 1'b0;
`ifdef SEQTX_PARITY_EN
            par_r       <= even_par(head_s);
`endif
          end else begin
            state_r     <= ST_IDLE;
            out_r       <= 1'b0;
            out_valid_r <= 1'b0;
            byte_done_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_r       <= 1'b0;
          out_valid_r <= 1'b0;
          byte_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seqtx_97.sv
// tb_seqtx_97: randomized + directed stimulus, byte-level reference model and scoreboard.
// The model tracks accepted bytes and the bit position of the frame currently on the wire.
module tb_seqtx_97;
  localparam int DEPTH = 4;
`ifdef SEQTX_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] InData = 8'h00;
  logic       InValid = 1'b0;
  logic       InReady, Out, OutValid, ByteDone, Busy;

  seqtx_97 #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .InData(InData), .InValid(InValid), .InReady(InReady),
    .Out(Out), .OutValid(OutValid), .ByteDone(ByteDone), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] data;
    int         edge_n;
  } ent_t;

  ent_t        bq[$];
  int          edge_cnt = 0;
  int          bit_pos = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic        log_en = 1'b0;
  logic [31:0] log_bits = 32'h0;
  int          log_n = 0;
  int          done_n = 0;

  function automatic logic frame_bit(input logic [7:0] d, input int p);
    if (p < 8) return d[7-p];
    return ^d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Model input side: record every accepted byte with the edge it was accepted on.
  always @(posedge Clk) begin
    edge_cnt++;
    if (Reset) begin
      bq.delete();
      bit_pos = 0;
    end else if (InValid && InReady) begin
      bq.push_back('{InData, edge_cnt});
    end
  end

  // Monitor: a byte accepted at an earlier edge must be on the wire, so gaps are errors.
  always @(negedge Clk) begin
    logic exp_v;
    int   fifo_n;
    exp_v  = (bq.size() > 0) && (bq[0].edge_n < edge_cnt);
    fifo_n = exp_v ? bq.size() - 1 : bq.size();
    check("out_valid", OutValid, exp_v);
    check("in_ready", InReady, fifo_n < DEPTH);
    check("busy", Busy, bq.size() != 0);
    if (exp_v) begin
      check("out_bit", Out, frame_bit(bq[0].data, bit_pos));
      check("byte_done", ByteDone, bit_pos == FRAME - 1);
      if (log_en) begin
        log_bits = {log_bits[30:0], Out};
        log_n++;
        if (ByteDone) done_n++;
      end
      bit_pos++;
      if (bit_pos == FRAME) begin
        void'(bq.pop_front());
        bit_pos = 0;
      end
    end else begin
      check("out_idle", Out, 1'b0);
      check("done_idle", ByteDone, 1'b0);
    end
  end

  task automatic send(input logic [7:0] d);
    logic acc;
    int   n;
    InValid = 1'b1;
    InData  = d;
    n = 0;
    do begin
      acc = InReady;
      @(posedge Clk); #2;
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    repeat (n) begin
      @(posedge Clk); #2;
    end
  endtask

  task automatic drain();
    int n;
    InValid = 1'b0;
    n = 0;
    while (bq.size() != 0 && n < 500) begin
      @(posedge Clk); #2;
      n++;
    end
    if (bq.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    idle(3);
  endtask

  initial begin
    int n;
    @(posedge Clk); #2;
    @(posedge Clk); #2;
    Reset = 1'b0;
    idle(20);

    // Directed pattern stream, gap-free across frames.
    log_en = 1'b1;
    log_n = 0;
    done_n = 0;
`ifdef SEQTX_PARITY_EN
    send(8'h97);
    send(8'h28);
    drain();
    log_en = 1'b0;
    check("stream_bits", {14'h0, log_bits[17:0]}, {14'h0, 18'b100101111_001010000});
    check("stream_len", log_n, 32'd18);
    check("stream_done", done_n, 32'd2);
`else
    send(8'h85);
    send(8'h97);
    send(8'h42);
    drain();
    log_en = 1'b0;
    check("stream_bits", {8'h0, log_bits[23:0]}, {8'h0, 24'h859742});
    check("stream_len", log_n, 32'd24);
    check("stream_done", done_n, 32'd3);
`endif

    // Overfill: InValid held high, backpressure timing checked by the monitor.
    for (int i = 1; i <= DEPTH + 2; i++) send(8'(i));
    drain();

    // Mid-frame reset during bit 3 of 0x53 with two bytes queued.
    send(8'h53);
    send(8'hAA);
    send(8'hBB);
    InValid = 1'b0;
    n = 0;
    while (!OutValid && n < 50) begin
      @(posedge Clk); #2;
      n++;
    end
    if (!OutValid) check("reset_wait_timeout", 32'd0, 32'd1);
    repeat (4) begin
      @(posedge Clk); #2;
    end
    Reset = 1'b1;
    @(posedge Clk); #2;
    Reset = 1'b0;
    check("post_reset_out", Out, 1'b0);
    check("post_reset_valid", OutValid, 1'b0);
    idle(30);

    // Pointer wrap with an incrementing pattern.
    for (int i = 0; i < 3 * DEPTH; i++) send(8'(8'h10 + i));
    drain();

    // Randomized traffic with one random mid-stream reset.
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin
        InValid = 1'b0;
        idle($urandom_range(0, 9));
        Reset = 1'b1;
        @(posedge Clk); #2;
        Reset = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 12));
      else send(8'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seqtx_97.md
# seqtx_97

Parallel-to-serial byte transmitter that produces the single-bit stream consumed by the serial sequence detectors (seqdec family). Bytes arrive on a valid/ready handshake, are buffered in a small FIFO, and are shifted out one bit per clock, MSB first, with no gaps between consecutive bytes. Its `Out` pin connects directly to a detector's `InA`, so a bench can drive detector patterns such as 0x85, 0x97, 0x42, 0x53 and 0x28 without hand-built bit vectors.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `Clk`  input  1  clock; all state updates on the rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `InData`  input  8  byte to transmit.
- `InValid`  input  1  `InData` is valid this cycle.
- `InReady`  output  1  FIFO can accept a byte this cycle.
- `Out`  output  1  serial data bit, registered.
- `OutValid`  output  1  `Out` carries a data (or parity) bit this cycle.
- `ByteDone`  output  1  one-cycle pulse coinciding with the final bit of each frame.
- `Busy`  output  1  FIFO not empty or a frame is in progress.

## Operation
- A push occurs at the rising edge where `InValid && InReady`. `InReady = !full`, decoded combinationally from the registered count. A push while full is impossible by construction.
- FIFO: `DEPTH` entries with wrap-around read and write pointers of log2(`DEPTH`) bits and a count of log2(`DEPTH`)+1 bits.
  - Simultaneous push and pop leave the count unchanged.
  - Pointers wrap modulo `DEPTH`.
- The shifter state machine has two states, IDLE and SHIFT.
  - IDLE → SHIFT: at the edge where the FIFO is non-empty. The head is popped into an 8-bit shift register, and the bit counter is set to 7 (8 when parity is enabled; see Configuration).
  - SHIFT: each edge shifts left by one and decrements the counter.
  - At the edge leaving the last bit: if the FIFO is non-empty, the next byte loads immediately (stays in SHIFT, no idle cycle); otherwise the machine goes to IDLE.
- The shifter pops from the FIFO only on a load. Total buffering is therefore `DEPTH` + 1 bytes.
- Output encoding:
  - `Out` = shift register bit 7 while in SHIFT; 0 in IDLE.
  - `OutValid` = 1 exactly while in SHIFT.
- `ByteDone` is high during the cycle in which `Out` carries the last bit of a frame.
- `Busy` = (count != 0) || SHIFT.
- Reset, including mid-frame: the frame is aborted, the FIFO is flushed, and the machine goes to IDLE. Reset has priority over a simultaneous push or pop.
- Reset values: `Out` = 0, `OutValid` = 0, `ByteDone` = 0, `Busy` = 0, `InReady` = 1 (count is 0).

## Timing
- Latency from a push into an empty FIFO with the shifter in IDLE:
  - Push at edge E0.
  - Load at E1; `Out` = bit 7 in the cycle after E1.
  - Bit 0 appears in the cycle after E8, with `ByteDone` = 1 in that cycle.
- Back-to-back bytes: the next byte's bit 7 follows the previous byte's bit 0 in the immediately following cycle. `OutValid` stays high continuously.
- Pop-to-ready: a load from a full FIFO raises `InReady` in the cycle after the load edge.
- Throughput: one byte per 8 cycles (9 with parity).

## Configuration
- `SEQTX_PARITY_EN` defined: each frame is 9 bits, namely the 8 data bits MSB first, then an even-parity bit (XOR of the 8 data bits).
  - `OutValid` = 1 during the parity bit.
  - `ByteDone` marks the parity cycle, not bit 0.
  - The next frame loads after the parity bit.
- Undefined: frames are 8 bits, with no parity logic or counter state beyond 3 bits.

## Test plan
- Reset, then hold `InValid` = 0 → `Out` = 0, `OutValid` = 0, `Busy` = 0, `InReady` = 1 for 20 cycles.
- Push 0x85, 0x97, 0x42 on consecutive cycles → `Out` = 10000101 10010111 01000010 over 24 consecutive cycles. `OutValid` is high for all 24, `ByteDone` pulses 3 times, 8 cycles apart, then IDLE. Fed into seqdec_97, this produces exactly one detector `Out` pulse, aligned to the 0x97 byte.
- Push `DEPTH` + 2 = 6 bytes (0x01 to 0x06) with `InValid` held high → 5 bytes are accepted, then `InReady` = 0. `InReady` returns to 1 the cycle after the second load. All 6 bytes are emitted in order with no gaps.
- Reset asserted for one cycle during bit 3 of 0x53, with 2 bytes queued → the cycle after reset, `Out` = 0 and `OutValid` = 0, and none of the queued bytes are ever emitted.
- Push and pop on the same edge with count = 2 → count stays 2. Pointer wrap is verified over 3 × `DEPTH` bytes of an incrementing pattern with no loss or reordering.
- With `SEQTX_PARITY_EN` defined: push 0x97 then 0x28 → `Out` = 10010111 1 00101000 0, with `ByteDone` on each parity cycle.
